// File: rtl/aes_sbox_pkg.sv
// Shared constants, loader state encoding and GF(2^8) helpers for the S-box SRAM loader.
package aes_sbox_pkg;

    localparam int unsigned SBOX_DEPTH   = 256;
    localparam logic [7:0]  AFFINE_C     = 8'h63;
    localparam logic [7:0]  INV_AFFINE_C = 8'h05;
    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B)
    localparam logic [7:0]  GF_POLY_LO   = 8'h1B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN,
        ST_VERIFY,
        ST_DONE
    } loader_state_e;

    // Multiply by x in GF(2^8) modulo 0x11B
    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY_LO : 8'h00);
    endfunction

    // Shift-and-add product in GF(2^8)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = gf_mul2(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/sbox_gen.sv
// Combinational AES S-box: field inverse plus affine map, forward or inverse direction.
module sbox_gen
    import aes_sbox_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] idx,
    output logic [7:0] val_c
);

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ AFFINE_C;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ INV_AFFINE_C;
    endfunction

    // Direction chosen at elaboration time
    always_comb begin
        val_c = 8'h00;
        if (INVERSE) val_c = gf_inv(affine_inv(idx));
        else         val_c = affine_fwd(gf_inv(idx));
    end

endmodule

// File: rtl/sbox_sram_loader.sv
// Loads the 256-entry S-box into a dual-port SRAM, optionally reads it back,
// then hands SRAM port 1 to the SubBytes datapath.
module sbox_sram_loader
    import aes_sbox_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          INVERSE    = 1'b0,
    parameter bit          VERIFY     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    input  logic                  user_csb1,
    input  logic [ADDR_WIDTH-1:0] user_addr1
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(SBOX_DEPTH - 1);

    loader_state_e         state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  vtail;
    logic                  csb1_q;
    logic [ADDR_WIDTH-1:0] addr1_q;
    logic                  cmp_vld;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] exp_addr_q;
    logic [7:0]            gen_val_c;

    sbox_gen #(
        .INVERSE (INVERSE)
    ) u_sbox_gen (
        .idx   (8'(cnt)),
        .val_c (gen_val_c)
    );

    // Loader FSM, write/read port drive and readback compare.
    // Port 1 is preloaded with address 0 on leaving DRAIN so each VERIFY
    // cycle's address register already shows cnt; its expected value follows
    // one stage behind to meet the returning read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            vtail      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
            sram_csb0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            csb1_q     <= 1'b1;
            addr1_q    <= '0;
            cmp_vld    <= 1'b0;
            exp_q      <= '0;
            exp_addr_q <= '0;
        end else begin
            cmp_vld <= 1'b0;
            if (cmp_vld && (sram_dout1 != exp_q) && !error) begin
                error    <= 1'b1;
                err_addr <= exp_addr_q;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_WRITE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    sram_csb0  <= 1'b0;
                    sram_addr0 <= cnt;
                    sram_din0  <= DATA_WIDTH'(gen_val_c);
                    cnt        <= ADDR_WIDTH'(cnt + 1'b1);
                    if (cnt == CNT_LAST) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    sram_csb0 <= 1'b1;
                    cnt       <= '0;
                    if (VERIFY) begin
                        state   <= ST_VERIFY;
                        csb1_q  <= 1'b0;
                        addr1_q <= '0;
                        vtail   <= 1'b0;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_VERIFY: begin
                    if (!vtail) begin
                        exp_q      <= DATA_WIDTH'(gen_val_c);
                        exp_addr_q <= cnt;
                        cmp_vld    <= 1'b1;
                        cnt        <= ADDR_WIDTH'(cnt + 1'b1);
                        addr1_q    <= ADDR_WIDTH'(cnt + 1'b1);
                        if (cnt == CNT_LAST) begin
                            csb1_q  <= 1'b1;
                            addr1_q <= '0;
                            vtail   <= 1'b1;
                        end
                    end else begin
                        state <= ST_DONE;
                        vtail <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Port 1 belongs to the datapath only once the table is loaded
    assign sram_csb1  = done ? user_csb1  : csb1_q;
    assign sram_addr1 = done ? user_addr1 : addr1_q;

endmodule

// File: tb/tb_sbox_sram_loader.sv
// Self-checking bench: two loaders (forward+verify, inverse without verify),
// each on a behavioural dual-port SRAM, with a write-stream scoreboard.
module tb_sbox_sram_loader;

    logic clk;
    logic rst;
    logic start_f, start_i;
    logic user_csb1;
    logic [7:0] user_addr1;
    logic inject;

    logic busy_f, done_f, error_f, csb0_f, csb1_f;
    logic [7:0] err_addr_f, addr0_f, din0_f, addr1_f, dout1_f;
    logic busy_i, done_i, error_i, csb0_i, csb1_i;
    logic [7:0] err_addr_i, addr0_i, din0_i, addr1_i, dout1_i;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    logic [7:0] mem_f [256];
    logic [7:0] mem_i [256];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t        q_f[$];
    wr_t        q_i[$];
    logic [7:0] rd_q[$];

    int rd_cnt_i = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sbox_sram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .INVERSE(1'b0), .VERIFY(1'b1)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .busy(busy_f), .done(done_f),
        .error(error_f), .err_addr(err_addr_f), .sram_csb0(csb0_f), .sram_addr0(addr0_f),
        .sram_din0(din0_f), .sram_csb1(csb1_f), .sram_addr1(addr1_f), .sram_dout1(dout1_f),
        .user_csb1(user_csb1), .user_addr1(user_addr1)
    );

    sbox_sram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .INVERSE(1'b1), .VERIFY(1'b0)) dut_i (
        .clk(clk), .rst(rst), .start(start_i), .busy(busy_i), .done(done_i),
        .error(error_i), .err_addr(err_addr_i), .sram_csb0(csb0_i), .sram_addr0(addr0_i),
        .sram_din0(din0_i), .sram_csb1(csb1_i), .sram_addr1(addr1_i), .sram_dout1(dout1_i),
        .user_csb1(1'b1), .user_addr1(8'h00)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM models: port inputs seen at negedge are those sampled at the next posedge;
    // that sample's write commits, and its read data appears, on the negedge after.
    logic       wp_f, rp_f, wp_i, rp_i;
    logic [7:0] wa_f, wd_f, ra_f, wa_i, wd_i, ra_i;
    initial begin
        wp_f = 1'b0; rp_f = 1'b0; wp_i = 1'b0; rp_i = 1'b0;
        dout1_f = 8'h00; dout1_i = 8'h00;
    end
    always @(negedge clk) begin
        if (wp_f) mem_f[wa_f] = wd_f;
        if (rp_f) dout1_f = (inject && (ra_f == 8'h10 || ra_f == 8'h20)) ? 8'h00 : mem_f[ra_f];
        wp_f = !csb0_f; wa_f = addr0_f; wd_f = din0_f;
        rp_f = !csb1_f; ra_f = addr1_f;
        if (wp_i) mem_i[wa_i] = wd_i;
        if (rp_i) dout1_i = mem_i[ra_i];
        wp_i = !csb0_i; wa_i = addr0_i; wd_i = din0_i;
        rp_i = !csb1_i; ra_i = addr1_i;
        if (!rst && !csb1_i) rd_cnt_i++;
    end

    // Write-stream scoreboard
    always @(negedge clk) begin
        if (!rst && csb0_f === 1'b0) begin
            chk("f_wr_expected", 32'(q_f.size() > 0), 32'd1);
            if (q_f.size() > 0) begin
                wr_t e;
                e = q_f.pop_front();
                chk("f_wr", 32'({addr0_f, din0_f}), 32'({e.a, e.d}));
            end
        end
        if (!rst && csb0_i === 1'b0) begin
            chk("i_wr_expected", 32'(q_i.size() > 0), 32'd1);
            if (q_i.size() > 0) begin
                wr_t e;
                e = q_i.pop_front();
                chk("i_wr", 32'({addr0_i, din0_i}), 32'({e.a, e.d}));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference table built by walking the multiplicative group with generator 3
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    endtask

    task automatic push_expected(input bit which);
        for (int i = 0; i < 256; i++) begin
            if (which) q_i.push_back('{a: 8'(i), d: inv_tab[i]});
            else       q_f.push_back('{a: 8'(i), d: fwd_tab[i]});
        end
    endtask

    // Pulse start at a negedge; returns the index of the edge after which done was seen.
    task automatic run_load(input bit which, input int restart_at, output int lat, output int bad);
        string pfx;
        pfx = which ? "i" : "f";
        push_expected(which);
        if (which) start_i = 1'b1; else start_f = 1'b1;
        lat = -1;
        bad = 0;
        for (int e = 0; e < 700; e++) begin
            @(negedge clk);
            start_f = 1'b0;
            start_i = 1'b0;
            if (e == 0) begin
                chk({pfx, "_busy_go"}, 32'(which ? busy_i : busy_f), 32'd1);
                chk({pfx, "_done_clr"}, 32'(which ? done_i : done_f), 32'd0);
                chk({pfx, "_err_clr"}, 32'(which ? error_i : error_f), 32'd0);
            end
            if (e == restart_at) begin
                if (which) start_i = 1'b1; else start_f = 1'b1;
            end
            if (which ? done_i : done_f) begin
                lat = e;
                break;
            end
            if (!(which ? busy_i : busy_f)) bad++;
            if (!which && e < 257 && !csb1_f) bad++;
        end
        chk({pfx, "_busy_end"}, 32'(which ? busy_i : busy_f), 32'd0);
    endtask

    initial begin
        int lat, bad, found;
        logic [7:0] ua [3];
        logic [7:0] exp_rd;
        ua[0] = 8'h53; ua[1] = 8'h00; ua[2] = 8'hFF;
        rst = 1'b1; start_f = 1'b0; start_i = 1'b0;
        user_csb1 = 1'b1; user_addr1 = 8'h00; inject = 1'b0;
        build_tables();

        // Reset holds both ports idle
        repeat (3) begin
            @(negedge clk);
            chk("rst_csb0", 32'({csb0_f, csb0_i}), 32'b11);
            chk("rst_csb1", 32'({csb1_f, csb1_i}), 32'b11);
        end
        chk("rst_flags", 32'({busy_f, done_f, error_f, busy_i, done_i, error_i}), 32'd0);
        chk("rst_err_addr", 32'(err_addr_f), 32'h00);
        chk("rst_addr0", 32'({addr0_f, din0_f}), 32'h0000);
        chk("rst_addr1", 32'(addr1_f), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Forward load with readback; early user request and a mid-load start must be ignored
        user_csb1 = 1'b0; user_addr1 = 8'h53;
        run_load(1'b0, 100, lat, bad);
        chk("f_done_lat", 32'(lat), 32'd514);
        chk("f_busy_leak", 32'(bad), 32'd0);
        chk("f_error", 32'(error_f), 32'd0);
        chk("f_q_empty", 32'(q_f.size()), 32'd0);
        chk("f_mem00", 32'(mem_f[8'h00]), 32'h63);
        chk("f_mem53", 32'(mem_f[8'h53]), 32'hED);
        chk("f_memFF", 32'(mem_f[8'hFF]), 32'h16);

        // Port 1 now belongs to the datapath
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            user_csb1 = 1'b0; user_addr1 = ua[k];
            #1;
            chk("user_mux", 32'({csb1_f, addr1_f}), 32'({1'b0, ua[k]}));
            rd_q.push_back(fwd_tab[ua[k]]);
            @(negedge clk); @(negedge clk); @(posedge clk); #1;
            exp_rd = rd_q.pop_front();
            chk("user_rd", 32'(dout1_f), 32'(exp_rd));
        end
        user_csb1 = 1'b1;
        @(negedge clk);

        // Inverse load, no readback pass
        rd_cnt_i = 0;
        run_load(1'b1, -1, lat, bad);
        chk("i_done_lat", 32'(lat), 32'd257);
        chk("i_busy_leak", 32'(bad), 32'd0);
        chk("i_reads", 32'(rd_cnt_i), 32'd0);
        chk("i_q_empty", 32'(q_i.size()), 32'd0);
        chk("i_mem63", 32'(mem_i[8'h63]), 32'h00);
        chk("i_mem16", 32'(mem_i[8'h16]), 32'hFF);

        // Corrupted readback at 0x10 and 0x20: first mismatch is latched
        inject = 1'b1;
        run_load(1'b0, -1, lat, bad);
        inject = 1'b0;
        chk("inj_done_lat", 32'(lat), 32'd514);
        chk("inj_error", 32'(error_f), 32'd1);
        chk("inj_err_addr", 32'(err_addr_f), 32'h10);

        // Reset in the middle of the write pass, then a clean reload
        push_expected(1'b0);
        start_f = 1'b1;
        found = 0;
        for (int e = 0; e < 400; e++) begin
            @(negedge clk);
            start_f = 1'b0;
            if (!csb0_f && addr0_f == 8'h80) begin
                found = 1;
                break;
            end
        end
        chk("abort_reached", 32'(found), 32'd1);
        rst = 1'b1;
        q_f.delete();
        q_i.delete();
        @(negedge clk);
        chk("abort_csb", 32'({csb0_f, csb1_f}), 32'b11);
        chk("abort_flags", 32'({busy_f, done_f}), 32'b00);
        rst = 1'b0;
        @(negedge clk);
        run_load(1'b0, -1, lat, bad);
        chk("reload_lat", 32'(lat), 32'd514);
        chk("reload_busy", 32'(bad), 32'd0);
        chk("reload_error", 32'(error_f), 32'd0);
        chk("reload_q_empty", 32'(q_f.size()), 32'd0);
        chk("reload_mem80", 32'(mem_f[8'h80]), 32'(fwd_tab[8'h80]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
